// File: rtl/qar_mem_arbiter_if.sv
// Signal bundle for the qar_core fetch/data ports and the unified memory bus.
// slave is the arbiter's view; master is the core + memory view.
interface qar_mem_arbiter_if;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        bus_owner;

  modport slave (
    input  imem_valid, imem_addr, mem_valid, mem_we, mem_addr, mem_wdata, bus_ready, bus_rdata,
    output imem_ready, imem_rdata, mem_ready, mem_rdata, bus_valid, bus_we, bus_addr, bus_wdata,
           bus_owner
  );

  modport master (
    output imem_valid, imem_addr, mem_valid, mem_we, mem_addr, mem_wdata, bus_ready, bus_rdata,
    input  imem_ready, imem_rdata, mem_ready, mem_rdata, bus_valid, bus_we, bus_addr, bus_wdata,
           bus_owner
  );
endinterface

// File: rtl/qar_mem_arbiter.sv
// Unified memory bus arbiter for qar_core: data port has priority, fetch is
// granted after DATA_BURST_MAX data grants, and a stalled bus times out.
module qar_mem_arbiter #(
  parameter int unsigned DATA_BURST_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  qar_mem_arbiter_if.slave port,
  input  logic             clear_err,
  output logic             timeout_err,
  output logic             timeout_sticky
);
  localparam int unsigned BURST_LIM = (DATA_BURST_MAX < 32'd1) ? 32'd1 : DATA_BURST_MAX;
  localparam int unsigned BW = $clog2(BURST_LIM + 32'd1);
  localparam int unsigned TW = (TIMEOUT_CYCLES < 32'd2) ? 32'd1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [BW-1:0]   burst_cnt_r;
  logic [TW-1:0]   tmo_cnt_r;
  logic            owner_r, we_r;
  logic [31:0]     addr_r, wdata_r;
  logic            imem_ready_r, mem_ready_r;
  logic [31:0]     imem_rdata_r, mem_rdata_r;
  logic            timeout_err_r, timeout_sticky_r;
  logic            grant_s, grant_data_s, done_s, tmo_s;
  logic            burst_full_s, tmo_hit_s;

  assign burst_full_s = (32'(burst_cnt_r) == BURST_LIM);
  assign tmo_hit_s    = (TIMEOUT_CYCLES != 32'd0) && (32'(tmo_cnt_r) == TIMEOUT_CYCLES - 32'd1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Next-state, grant selection and completion decode
  always_comb begin
    state_s      = state_r;
    grant_s      = 1'b0;
    grant_data_s = 1'b0;
    done_s       = 1'b0;
    tmo_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (port.mem_valid && !(port.imem_valid && burst_full_s)) begin
          grant_s      = 1'b1;
          grant_data_s = 1'b1;
          state_s      = S_BUSY;
        end else if (port.imem_valid) begin
          grant_s = 1'b1;
          state_s = S_BUSY;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BUSY: begin
        // A completing bus_ready beats a timeout landing in the same cycle
        if (port.bus_ready) begin
          done_s  = 1'b1;
          state_s = S_RESP;
        end else if (tmo_hit_s) begin
          tmo_s   = 1'b1;
          state_s = S_RESP;
        end else begin
          state_s = S_BUSY;
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Latch the granted request and track consecutive data grants against a waiting fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_r     <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      burst_cnt_r <= '0;
    end else if (grant_s) begin
      owner_r <= grant_data_s;
      we_r    <= grant_data_s && port.mem_we;
      addr_r  <= grant_data_s ? port.mem_addr : port.imem_addr;
      wdata_r <= grant_data_s ? port.mem_wdata : 32'h0000_0000;
      if (grant_data_s && port.imem_valid) begin
        burst_cnt_r <= burst_full_s ? burst_cnt_r : burst_cnt_r + BW'(1);
      end else begin
        burst_cnt_r <= '0;
      end
    end
  end

  // Busy-cycle counter for the bus timeout
  always_ff @(posedge clk) begin
    if (!rst_n)                 tmo_cnt_r <= '0;
    else if (grant_s)           tmo_cnt_r <= '0;
    else if (state_r == S_BUSY) tmo_cnt_r <= tmo_cnt_r + TW'(1);
  end

  // Owner response: ready pulses for one cycle in RESP, rdata holds otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_ready_r <= 1'b0;
      mem_ready_r  <= 1'b0;
      imem_rdata_r <= 32'h0000_0000;
      mem_rdata_r  <= 32'h0000_0000;
    end else begin
      imem_ready_r <= 1'b0;
      mem_ready_r  <= 1'b0;
      if (done_s || tmo_s) begin
        if (owner_r) begin
          mem_ready_r <= 1'b1;
          mem_rdata_r <= done_s ? port.bus_rdata : 32'h0000_0000;
        end else begin
          imem_ready_r <= 1'b1;
          imem_rdata_r <= done_s ? port.bus_rdata : 32'h0000_0000;
        end
      end
    end
  end

  // Timeout error pulse and sticky flag; a new timeout wins over clear_err
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_err_r    <= 1'b0;
      timeout_sticky_r <= 1'b0;
    end else begin
      timeout_err_r <= tmo_s;
      if (tmo_s)          timeout_sticky_r <= 1'b1;
      else if (clear_err) timeout_sticky_r <= 1'b0;
    end
  end

  // bus_valid drops combinationally with bus_ready so a finished request is never re-latched
  assign port.bus_valid  = (state_r == S_BUSY) && !port.bus_ready;
  assign port.bus_we     = we_r;
  assign port.bus_addr   = addr_r;
  assign port.bus_wdata  = wdata_r;
  assign port.bus_owner  = owner_r;
  assign port.imem_ready = imem_ready_r;
  assign port.imem_rdata = imem_rdata_r;
  assign port.mem_ready  = mem_ready_r;
  assign port.mem_rdata  = mem_rdata_r;
  assign timeout_err     = timeout_err_r;
  assign timeout_sticky  = timeout_sticky_r;
endmodule

// File: tb/tb_qar_mem_arbiter.sv
// Directed bench for qar_mem_arbiter: scoreboard queues of expected read data,
// a variable-latency memory responder, and immediate-assertion checks.
module tb_qar_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic clear_err;
  logic timeout_err;
  logic timeout_sticky;

  always #5 clk = ~clk;

  qar_mem_arbiter_if bif ();

  qar_mem_arbiter #(.DATA_BURST_MAX(4), .TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .port           (bif.slave),
    .clear_err      (clear_err),
    .timeout_err    (timeout_err),
    .timeout_sticky (timeout_sticky)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] fq[$];
  logic [31:0] dq[$];
  logic [31:0] fetch_stim[$];
  dreq_t       data_stim[$];
  bit          f_out = 1'b0;
  bit          d_out = 1'b0;
  int          f_pulses = 0;
  int          d_pulses = 0;
  int          bv_cnt = 0;
  int          f_issue_cyc = 0;
  int          f_lat = 0;
  logic        last_terr = 1'b0;
  int          order[$];
  int          exp_order [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  // memory responder state
  bit          auto_on = 1'b0;
  int          wait_cfg = 0;
  int          man_req = 0;
  int          man_done = 0;
  bit          active = 1'b0;
  int          wcnt = 0;
  int          txn_cnt = 0;
  logic [31:0] bmem [256];
  bit          mem_init = 1'b0;
  logic [31:0] last_addr = 32'h0;
  logic        last_we = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0050_0093;
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Memory model: answers bus_valid after wait_cfg cycles (4 = random 0..3), or a manual pulse
  always @(negedge clk) begin
    logic       v;
    logic [7:0] idx;
    v   = bif.bus_valid;
    idx = bif.bus_addr[9:2];
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) bmem[i] = init_word(i);
      bif.bus_rdata = 32'h0;
      mem_init = 1'b1;
    end
    bif.bus_ready = 1'b0;
    if (man_req != man_done) begin
      bif.bus_ready = 1'b1;
      bif.bus_rdata = 32'hDEAD_BEEF;
      man_done++;
    end else if (auto_on && v) begin
      if (!active) begin
        active = 1'b1;
        wcnt = (wait_cfg > 3) ? int'($urandom_range(0, 3)) : wait_cfg;
      end
      if (wcnt == 0) begin
        bif.bus_ready = 1'b1;
        active = 1'b0;
        txn_cnt++;
        last_addr = bif.bus_addr;
        last_we = bif.bus_we;
        if (bif.bus_we) begin
          bmem[idx] = bif.bus_wdata;
          bif.bus_rdata = ~bif.bus_wdata;
        end else begin
          bif.bus_rdata = bmem[idx];
        end
      end else begin
        wcnt--;
      end
    end else begin
      active = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: consume ready pulses against the scoreboard, then issue queued requests
  task automatic step();
    logic [31:0] e;
    logic [31:0] a;
    dreq_t       r;
    @(negedge clk);
    cyc++;
    if (bif.bus_valid) bv_cnt++;
    if (bif.imem_ready) begin
      f_pulses++;
      chk("fetch_outstanding", 32'(f_out), 32'd1);
      chk("fetch_owner", 32'(bif.bus_owner), 32'd0);
      e = 32'hFFFF_FFFF;
      if (fq.size() > 0) e = fq.pop_front();
      chk("fetch_rdata", bif.imem_rdata, e);
      f_lat = cyc - f_issue_cyc;
      last_terr = timeout_err;
      order.push_back(0);
      f_out = 1'b0;
      bif.imem_valid = 1'b0;
    end
    if (bif.mem_ready) begin
      d_pulses++;
      chk("data_outstanding", 32'(d_out), 32'd1);
      chk("data_owner", 32'(bif.bus_owner), 32'd1);
      e = 32'hFFFF_FFFF;
      if (dq.size() > 0) e = dq.pop_front();
      chk("data_rdata", bif.mem_rdata, e);
      order.push_back(1);
      d_out = 1'b0;
      bif.mem_valid = 1'b0;
    end
    if (!f_out && fetch_stim.size() > 0) begin
      a = fetch_stim.pop_front();
      bif.imem_addr = a;
      bif.imem_valid = 1'b1;
      f_out = 1'b1;
      f_issue_cyc = cyc;
      fq.push_back(ref_mem[a[9:2]]);
    end
    if (!d_out && data_stim.size() > 0) begin
      r = data_stim.pop_front();
      bif.mem_we = r.we;
      bif.mem_addr = r.addr;
      bif.mem_wdata = r.wdata;
      bif.mem_valid = 1'b1;
      d_out = 1'b1;
      if (r.we) begin
        ref_mem[r.addr[9:2]] = r.wdata;
        dq.push_back(~r.wdata);
      end else begin
        dq.push_back(ref_mem[r.addr[9:2]]);
      end
    end
  endtask

  task automatic run_all(input int budget);
    int n;
    n = 0;
    while ((f_out || d_out || fetch_stim.size() > 0 || data_stim.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("run_within_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int f0, d0, t0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    clear_err = 1'b0;
    bif.imem_valid = 1'b0;
    bif.imem_addr = 32'h0;
    bif.mem_valid = 1'b0;
    bif.mem_we = 1'b0;
    bif.mem_addr = 32'h0;
    bif.mem_wdata = 32'h0;

    // Reset state
    step(); step(); step();
    chk("rst_imem_ready", 32'(bif.imem_ready), 32'd0);
    chk("rst_mem_ready", 32'(bif.mem_ready), 32'd0);
    chk("rst_imem_rdata", bif.imem_rdata, 32'h0);
    chk("rst_mem_rdata", bif.mem_rdata, 32'h0);
    chk("rst_bus_valid", 32'(bif.bus_valid), 32'd0);
    chk("rst_bus_owner", 32'(bif.bus_owner), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_timeout_sticky", 32'(timeout_sticky), 32'd0);
    rst_n = 1'b1;
    step();

    // Single fetch, two wait cycles
    auto_on = 1'b1;
    wait_cfg = 2;
    f0 = f_pulses; d0 = d_pulses;
    fetch_stim.push_back(32'h0000_0010);
    run_all(20);
    chk("single_fetch_pulses", 32'(f_pulses - f0), 32'd1);
    chk("single_fetch_no_data", 32'(d_pulses - d0), 32'd0);
    chk("single_fetch_bus_addr", last_addr, 32'h0000_0010);
    chk("single_fetch_bus_we", 32'(last_we), 32'd0);
    chk("single_fetch_latency", 32'(f_lat), 32'd4);
    step();
    chk("fetch_ready_one_cycle", 32'(bif.imem_ready), 32'd0);

    // Store then load
    wait_cfg = 1;
    f0 = f_pulses; d0 = d_pulses;
    data_stim.push_back('{we: 1'b1, addr: 32'h0000_0040, wdata: 32'h0000_1234});
    data_stim.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0000_0000});
    run_all(30);
    chk("store_load_pulses", 32'(d_pulses - d0), 32'd2);
    chk("store_load_no_fetch", 32'(f_pulses - f0), 32'd0);
    chk("store_mem_word16", bmem[16], 32'h0000_1234);
    chk("load_rdata_hold", bif.mem_rdata, 32'h0000_1234);

    // Timeout: memory never answers
    auto_on = 1'b0;
    step();
    bv_cnt = 0;
    bif.imem_addr = 32'h0000_0080;
    bif.imem_valid = 1'b1;
    f_out = 1'b1;
    f_issue_cyc = cyc;
    fq.push_back(32'h0);
    run_all(40);
    chk("tmo_busy_cycles", 32'(bv_cnt), 32'd8);
    chk("tmo_latency", 32'(f_lat), 32'd9);
    chk("tmo_err_with_ready", 32'(last_terr), 32'd1);
    chk("tmo_sticky_set", 32'(timeout_sticky), 32'd1);
    step();
    chk("tmo_err_one_cycle", 32'(timeout_err), 32'd0);
    chk("tmo_sticky_holds", 32'(timeout_sticky), 32'd1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("tmo_sticky_cleared", 32'(timeout_sticky), 32'd0);

    // Reset mid-transaction, then a late bus_ready in IDLE
    f0 = f_pulses;
    bif.imem_addr = 32'h0000_0024;
    bif.imem_valid = 1'b1;
    f_out = 1'b1;
    step(); step(); step();
    chk("midop_busy", 32'(bif.bus_valid), 32'd1);
    rst_n = 1'b0;
    bif.imem_valid = 1'b0;
    f_out = 1'b0;
    step(); step();
    rst_n = 1'b1;
    man_req++;
    step(); step(); step();
    chk("midop_no_ready", 32'(f_pulses - f0), 32'd0);
    chk("midop_imem_rdata", bif.imem_rdata, 32'h0);
    chk("midop_mem_rdata", bif.mem_rdata, 32'h0);
    chk("midop_bus_valid", 32'(bif.bus_valid), 32'd0);
    chk("midop_owner", 32'(bif.bus_owner), 32'd0);
    chk("midop_late_ready_seen", 32'(man_done), 32'(man_req));
    auto_on = 1'b1;
    wait_cfg = 0;
    fetch_stim.push_back(32'h0000_0024);
    run_all(20);
    chk("midop_next_fetch", 32'(f_pulses - f0), 32'd1);
    chk("midop_next_latency", 32'(f_lat), 32'd2);

    // Contention: both ports held continuously
    order.delete();
    fetch_stim.push_back(32'h0000_0000);
    fetch_stim.push_back(32'h0000_0004);
    for (int k = 0; k < 8; k++)
      data_stim.push_back('{we: 1'b0, addr: 32'h0000_0100 + 32'(k * 4), wdata: 32'h0});
    run_all(200);
    chk("contention_count", 32'(order.size()), 32'd10);
    for (int k = 0; k < 10; k++) chk($sformatf("grant_order_%0d", k), 32'(order[k]), 32'(exp_order[k]));

    // Random mixed traffic with 0..3 wait cycles
    wait_cfg = 4;
    f0 = f_pulses; d0 = d_pulses; t0 = txn_cnt;
    for (int i = 0; i < 100; i++) begin
      fetch_stim.push_back({22'd0, 2'b00, 6'($urandom_range(0, 63)), 2'b00});
      data_stim.push_back('{we: 1'($urandom_range(0, 1)),
                            addr: {22'd0, 2'b01, 6'($urandom_range(0, 63)), 2'b00},
                            wdata: 32'($urandom)});
    end
    run_all(5000);
    chk("rand_bus_txns", 32'(txn_cnt - t0), 32'd200);
    chk("rand_fetch_pulses", 32'(f_pulses - f0), 32'd100);
    chk("rand_data_pulses", 32'(d_pulses - d0), 32'd100);
    chk("rand_fq_empty", 32'(fq.size()), 32'd0);
    chk("rand_dq_empty", 32'(dq.size()), 32'd0);
    step(); step();
    chk("rand_idle_after", 32'(bif.bus_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
